// File: rtl/mode_select_ctrl.sv
// Registered one-hot mode sequencer with break-before-make blanking between modes.
// Optional change counter (port change_cnt) is built when MODE_CHANGE_CNT_EN is defined.
module mode_select_ctrl #(
  parameter int MODE_W     = 2,
  parameter int SETTLE_CYC = 4
`ifdef MODE_CHANGE_CNT_EN
  , parameter int CNT_W    = 8
`endif
) (
  input  logic                       clk,
  input  logic                       Reset,
  input  logic                       Enable,
  input  logic [MODE_W-1:0]          Mode,
  input  logic                       mode_req,
  output logic [(1 << MODE_W)-1:0]   D,
  output logic [MODE_W-1:0]          mode_q,
  output logic                       busy,
  output logic                       changed
`ifdef MODE_CHANGE_CNT_EN
  , output logic [CNT_W-1:0]         change_cnt
`endif
);

  localparam int NM = 1 << MODE_W;
  localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  typedef enum logic [1:0] {OFF, ACTIVE, SETTLE} state_t;

  state_t            state, stateNext;
  logic [MODE_W-1:0] pending, pendingNext, modeNext;
  logic [SW-1:0]     settle, settleNext;
  logic [NM-1:0]     dNext;
  logic              busyNext, changedNext;

  function automatic logic [NM-1:0] oneHot(input logic [MODE_W-1:0] m);
    return NM'(1) << m;
  endfunction

  // State and every output are registered; all next values come from the decode below.
  always_ff @(posedge clk) begin
    if (Reset) begin
      state   <= OFF;
      mode_q  <= '0;
      pending <= '0;
      settle  <= '0;
      D       <= '0;
      busy    <= 1'b0;
      changed <= 1'b0;
    end else begin
      state   <= stateNext;
      mode_q  <= modeNext;
      pending <= pendingNext;
      settle  <= settleNext;
      D       <= dNext;
      busy    <= busyNext;
      changed <= changedNext;
    end
  end

  // Outputs default to blanked; only an ACTIVE destination drives a one-hot bit.
  always_comb begin
    stateNext   = state;
    modeNext    = mode_q;
    pendingNext = pending;
    settleNext  = settle;
    dNext       = '0;
    busyNext    = 1'b0;
    changedNext = 1'b0;
    case (state)
      OFF: begin
        if (mode_req) modeNext = Mode;
        if (Enable) begin
          stateNext = ACTIVE;
          dNext     = oneHot(modeNext);
        end
      end
      ACTIVE: begin
        if (!Enable) begin
          stateNext = OFF;
          if (mode_req) modeNext = Mode;
        end else if (mode_req && (Mode != mode_q)) begin
          pendingNext = Mode;
          busyNext    = 1'b1;
          settleNext  = SW'(SETTLE_CYC - 1);
          stateNext   = SETTLE;
        end else begin
          dNext = oneHot(mode_q);
        end
      end
      SETTLE: begin
        // Dropping Enable still commits the pending code, but leaves D blank.
        if (!Enable) begin
          modeNext    = pending;
          changedNext = 1'b1;
          stateNext   = OFF;
        end else if (settle == '0) begin
          modeNext    = pending;
          dNext       = oneHot(pending);
          changedNext = 1'b1;
          stateNext   = ACTIVE;
        end else begin
          busyNext   = 1'b1;
          settleNext = settle - 1'b1;
        end
      end
      default: stateNext = OFF;
    endcase
  end

`ifdef MODE_CHANGE_CNT_EN
  // Saturating count of commits, advanced on the same edge that raises changed.
  always_ff @(posedge clk) begin
    if (Reset)
      change_cnt <= '0;
    else if (changedNext && (change_cnt != '1))
      change_cnt <= change_cnt + 1'b1;
  end
`else
  // Counter omitted in this build.
`endif

endmodule

// File: tb/tb_mode_select_ctrl.sv
// Self-checking bench for mode_select_ctrl: abstract cycle model plus directed literal checks.
// A second instance (MODE_W=3, SETTLE_CYC=1) covers the widest code and the shortest blanking.
module tb_mode_select_ctrl;

  localparam int SETTLE = 4;
  localparam int CNT_MAX = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       modeReq = 1'b0;
  logic [1:0] modeIn = '0;
  logic [3:0] dOut;
  logic [1:0] modeQ;
  logic       busyOut, changedOut;

  logic       enable3 = 1'b0;
  logic       modeReq3 = 1'b0;
  logic [2:0] modeIn3 = '0;
  logic [7:0] dOut3;
  logic [2:0] modeQ3;
  logic       busyOut3, changedOut3;

`ifdef MODE_CHANGE_CNT_EN
  logic [1:0] cntOut;
  logic [1:0] cntOut3;
`endif

  int errors = 0;
  int checks = 0;
  bit checkEn = 1'b0;

  // Abstract model: on/off, committed mode, remaining blank cycles, target of the blanking.
  bit mOn = 1'b0;
  int mMode = 0;
  int mTarget = 0;
  int mBlank = 0;
  bit mChg = 1'b0;
  int mCnt = 0;

  always #5 clk = ~clk;

  mode_select_ctrl #(
    .MODE_W(2), .SETTLE_CYC(SETTLE)
`ifdef MODE_CHANGE_CNT_EN
    , .CNT_W(2)
`endif
  ) dut (
    .clk(clk), .Reset(reset), .Enable(enable), .Mode(modeIn), .mode_req(modeReq),
    .D(dOut), .mode_q(modeQ), .busy(busyOut), .changed(changedOut)
`ifdef MODE_CHANGE_CNT_EN
    , .change_cnt(cntOut)
`endif
  );

  mode_select_ctrl #(
    .MODE_W(3), .SETTLE_CYC(1)
`ifdef MODE_CHANGE_CNT_EN
    , .CNT_W(2)
`endif
  ) dut3 (
    .clk(clk), .Reset(reset), .Enable(enable3), .Mode(modeIn3), .mode_req(modeReq3),
    .D(dOut3), .mode_q(modeQ3), .busy(busyOut3), .changed(changedOut3)
`ifdef MODE_CHANGE_CNT_EN
    , .change_cnt(cntOut3)
`endif
  );

  // Model update from the inputs seen at each rising edge.
  always @(posedge clk) begin
    mChg = 1'b0;
    if (reset) begin
      mOn = 1'b0; mMode = 0; mTarget = 0; mBlank = 0; mCnt = 0;
    end else if (mBlank > 0) begin
      if (!enable || mBlank == 1) begin
        mMode = mTarget;
        mBlank = 0;
        mChg = 1'b1;
        if (mCnt < CNT_MAX) mCnt++;
        if (!enable) mOn = 1'b0;
      end else begin
        mBlank--;
      end
    end else if (mOn) begin
      if (!enable) begin
        mOn = 1'b0;
        if (modeReq) mMode = int'(modeIn);
      end else if (modeReq && int'(modeIn) != mMode) begin
        mTarget = int'(modeIn);
        mBlank = SETTLE;
      end
    end else begin
      if (modeReq) mMode = int'(modeIn);
      if (enable) mOn = 1'b1;
    end
  end

  // Every-cycle comparison of the main instance against the model.
  always @(negedge clk) begin
    if (checkEn) begin
      int expD;
      int ones;
      expD = (mOn && mBlank == 0) ? (1 << mMode) : 0;
      ones = $countones(dOut);
      checks += 5;
      if (int'(dOut) != expD) begin
        errors++;
        $display("[TB] FAIL model D: got %0h want %0h at %0t", dOut, expD, $time);
      end
      if (int'(modeQ) != mMode) begin
        errors++;
        $display("[TB] FAIL model mode_q: got %0d want %0d at %0t", modeQ, mMode, $time);
      end
      if (busyOut != (mBlank > 0)) begin
        errors++;
        $display("[TB] FAIL model busy: got %0b want %0b at %0t", busyOut, (mBlank > 0), $time);
      end
      if (changedOut != mChg) begin
        errors++;
        $display("[TB] FAIL model changed: got %0b want %0b at %0t", changedOut, mChg, $time);
      end
      if (ones > 1) begin
        errors++;
        $display("[TB] FAIL onehot popcount: got %0d want <=1 at %0t", ones, $time);
      end
`ifdef MODE_CHANGE_CNT_EN
      checks++;
      if (int'(cntOut) != mCnt) begin
        errors++;
        $display("[TB] FAIL model change_cnt: got %0d want %0d at %0t", cntOut, mCnt, $time);
      end
`endif
    end
  end

  task automatic applyStimulus(input bit r, input bit en, input bit req, input int m);
    reset = r;
    enable = en;
    modeReq = req;
    modeIn = 2'(m);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h want %0h", name, actual, expected);
    end
  endtask

  initial begin
    applyStimulus(1, 0, 0, 0);
    checkEn = 1'b1;
    applyStimulus(1, 0, 0, 0);
    checkOutput("reset D", int'(dOut), 0);
    checkOutput("reset mode_q", int'(modeQ), 0);
    checkOutput("reset busy", int'(busyOut), 0);

    applyStimulus(0, 1, 0, 0);
    checkOutput("enable D", int'(dOut), 4'b0001);
    checkOutput("enable busy", int'(busyOut), 0);

    // Accepted 0 -> 2 change: four blank cycles, then commit.
    applyStimulus(0, 1, 1, 2);
    for (int i = 0; i < SETTLE - 1; i++) begin
      checkOutput("settle D", int'(dOut), 0);
      checkOutput("settle busy", int'(busyOut), 1);
      applyStimulus(0, 1, 0, 0);
    end
    checkOutput("settle last busy", int'(busyOut), 1);
    applyStimulus(0, 1, 0, 0);
    checkOutput("commit D", int'(dOut), 4'b0100);
    checkOutput("commit mode_q", int'(modeQ), 2);
    checkOutput("commit changed", int'(changedOut), 1);
    applyStimulus(0, 1, 0, 0);
    checkOutput("changed pulse width", int'(changedOut), 0);

    // Request during busy is dropped; same-code request in ACTIVE is ignored.
    applyStimulus(0, 1, 1, 0);
    applyStimulus(0, 1, 1, 3);
    for (int i = 0; i < SETTLE - 1; i++) applyStimulus(0, 1, 0, 0);
    checkOutput("busy req dropped D", int'(dOut), 4'b0001);
    checkOutput("busy req dropped mode_q", int'(modeQ), 0);
    applyStimulus(0, 1, 1, 0);
    applyStimulus(0, 1, 0, 0);
    checkOutput("same code D", int'(dOut), 4'b0001);
    checkOutput("same code changed", int'(changedOut), 0);

    // Abort blanking on the second SETTLE cycle of a 0 -> 1 change.
    applyStimulus(0, 1, 1, 1);
    applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("abort D", int'(dOut), 0);
    checkOutput("abort mode_q", int'(modeQ), 1);
    checkOutput("abort changed", int'(changedOut), 1);
    checkOutput("abort busy", int'(busyOut), 0);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0);
    checkOutput("re-enable D", int'(dOut), 4'b0010);

    // Disable with a same-cycle request loads directly; OFF load plus enable in one cycle.
    applyStimulus(0, 0, 1, 3);
    checkOutput("disable load mode_q", int'(modeQ), 3);
    checkOutput("disable load changed", int'(changedOut), 0);
    applyStimulus(0, 1, 1, 2);
    checkOutput("off load enable D", int'(dOut), 4'b0100);

    // Reset in the middle of blanking discards the pending code.
    applyStimulus(0, 1, 1, 0);
    applyStimulus(0, 1, 0, 0);
    applyStimulus(1, 1, 0, 0);
    checkOutput("mid reset D", int'(dOut), 0);
    checkOutput("mid reset mode_q", int'(modeQ), 0);
    checkOutput("mid reset busy", int'(busyOut), 0);
    checkOutput("mid reset changed", int'(changedOut), 0);
`ifdef MODE_CHANGE_CNT_EN
    checkOutput("mid reset change_cnt", int'(cntOut), 0);
`endif

    // Five accepted changes back to back.
    applyStimulus(0, 1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 1, 1, (i + 1) % 4);
      for (int k = 0; k < SETTLE; k++) applyStimulus(0, 1, 0, 0);
      checkOutput("loop commit D", int'(dOut), 1 << ((i + 1) % 4));
      checkOutput("loop changed", int'(changedOut), 1);
`ifdef MODE_CHANGE_CNT_EN
      checkOutput("loop change_cnt", int'(cntOut), (i < 2) ? i + 1 : 3);
`endif
    end

    // Wide instance: top code and single-cycle blanking.
    enable3 = 1'b1; modeReq3 = 1'b1; modeIn3 = 3'd7;
    applyStimulus(0, 1, 0, 0);
    modeReq3 = 1'b0;
    checkOutput("wide D mode 7", int'(dOut3), 8'h80);
    checkOutput("wide mode_q", int'(modeQ3), 7);
    modeReq3 = 1'b1; modeIn3 = 3'd2;
    applyStimulus(0, 1, 0, 0);
    modeReq3 = 1'b0;
    checkOutput("wide settle D", int'(dOut3), 0);
    checkOutput("wide settle busy", int'(busyOut3), 1);
    applyStimulus(0, 1, 0, 0);
    checkOutput("wide commit D", int'(dOut3), 8'h04);
    checkOutput("wide commit changed", int'(changedOut3), 1);
    applyStimulus(0, 1, 0, 0);
    checkOutput("wide changed pulse", int'(changedOut3), 0);

    checkEn = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
